rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//  Parametrised N-channel registered multiplexer. Generalises the 2:1 select mux to NUM_CH
//  channels of DATA_W bits with valid/ready handshakes on every input and on the output.
//  Two modes: fixed select (the sel port picks the channel) or round-robin arbitration across
//  requesting channels. One output register stage; sits between multiple producers and one consumer.
// PARAMETERS
//  NUM_CH  4  number of input channels (>=2)
//  DATA_W  8  data width per channel
//  SEL_W   2  width of sel/out_ch; must equal max(1, ceil(log2(NUM_CH)))
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               asynchronous, active-high reset
//  mode       in   1               0 = round-robin, 1 = fixed select
//  sel        in   SEL_W           channel index used when mode=1
//  in_valid   in   NUM_CH          per-channel valid
//  in_ready   out  NUM_CH          per-channel ready (combinational)
//  in_data    in   NUM_CH*DATA_W   flattened; channel i = in_data[i*DATA_W +: DATA_W]
//  out_valid  out  1               output register holds a word
//  out_ready  in   1               consumer accepts the word
//  out_data   out  DATA_W          registered data
//  out_ch     out  SEL_W           registered source channel index of out_data
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, out_data=0, out_ch=0, rr pointer=NUM_CH-1 (ch0 has first priority).
//    in_ready=0 while rst=1. A transfer in flight at reset is dropped.
//  - load_en = !out_valid | out_ready. Output register loads when load_en and a grant exists.
//  - Grant (one-hot, combinational, at most one bit):
//    - mode=0: first i with in_valid[i], searching ptr+1, ptr+2, ... mod NUM_CH.
//    - mode=1: grant[sel] = in_valid[sel]. sel >= NUM_CH -> no grant.
//  - in_ready[i] = load_en & grant[i] & !rst. An input transfer occurs when in_valid[i] & in_ready[i].
//  - On transfer from channel g: next cycle out_valid=1, out_data=channel g data, out_ch=g.
//    Latency is 1 cycle, input to output.
//  - Pointer update: ptr <= g on every transfer in mode 0. Pointer is unchanged in mode 1
//    and unchanged when no transfer occurs.
//  - Output accept without a new load (out_valid & out_ready & no grant): out_valid <= 0;
//    out_data and out_ch hold their last value.
//  - Simultaneous output accept and input load: the register is replaced in the same edge.
//    Sustained throughput is 1 word/cycle.
//  - Backpressure (out_valid & !out_ready): every in_ready=0. out_data, out_ch and out_valid
//    stay stable until accepted.
//  - Changes to mode or sel affect only the grant for the next load. A held output word is never altered.
//  - Inputs are not required to hold in_valid. A channel that drops valid before its grant loses its turn silently.
//  - Fairness (mode 0): with k channels continuously valid and out_ready=1, each is served exactly once per k cycles.
// TESTING
//  1. Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0,
//     in_ready=0 asynchronously.
//  2. Fixed mode: mode=1, sel=2, all valid, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100;
//     next cycle out_data=8'hA5, out_ch=2. sel=2->3 -> ch3 data follows on the next cycle.
//  3. Round-robin: mode=0, all 4 valid, out_ready=1 from reset -> out_ch sequence 0,1,2,3,0,...
//     one word per cycle.
//  4. Sparse RR: only ch1 and ch3 valid -> out_ch alternates 1,3,1,3. Drop ch3 -> ch1 every cycle.
//  5. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data stable.
//     Raise out_ready -> held word accepted, next word loaded on the same edge.
//  6. Out-of-range sel: NUM_CH=3, SEL_W=2, mode=1, sel=3 -> no grant, in_ready=0, out_valid
//     falls after the last accept.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// N-channel registered multiplexer with valid/ready handshakes.
// Channel choice is either fixed by sel (mode=1) or round-robin over the requesting inputs (mode=0).
module rr_mux_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch
);

    logic [SEL_W-1:0]  ptr;
    logic [NUM_CH-1:0] grant;
    logic              rr_found;
    logic [SEL_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic              load_en;
    logic              xfer;

    // Round-robin search starts one past the last served channel and wraps.
    always_comb begin
        grant    = '0;
        rr_found = 1'b0;
        if (mode) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel == SEL_W'(i))
                    grant[i] = in_valid[i];
            end
        end else begin
            for (int off = 1; off <= NUM_CH; off++) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!rr_found && in_valid[i] && (i == (int'(ptr) + off) % NUM_CH)) begin
                        grant[i] = 1'b1;
                        rr_found = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                grant_idx  = SEL_W'(i);
                grant_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign in_ready = grant & {NUM_CH{load_en && !rst}};
    assign xfer     = load_en && (|grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SEL_W'(NUM_CH - 1);
        end else if (load_en) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                if (!mode)
                    ptr <= grant_idx;
            end else begin
                // Accepted with nothing to replace it: data and channel keep their last value.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed vector table, reset and out-of-range sel
// sequences, and randomized traffic against a queue-free behavioural model.
module tb_rr_mux_arbiter;

    localparam int N = 4;
    localparam logic [31:0] FIXED_DATA = {8'h33, 8'hA5, 8'h22, 8'h11};

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;

    logic        b_mode;
    logic [1:0]  b_sel;
    logic [2:0]  b_valid;
    logic [2:0]  b_ready;
    logic [23:0] b_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_ch;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.NUM_CH(4), .DATA_W(8), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
    );

    rr_mux_arbiter #(.NUM_CH(3), .DATA_W(8), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst), .mode(b_mode), .sel(b_sel),
        .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ch(b_out_ch)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_ready;
        logic       exp_ov;
        logic [1:0] exp_ch;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[19];

    // Behavioural model state
    bit      m_valid;
    int      m_data;
    int      m_ch;
    int      m_ptr;

    function automatic int model_grant();
        if (mode) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_cycle(input string tag);
        int g;
        bit le;
        logic [3:0] exp_rdy;
        @(negedge clk);
        g  = model_grant();
        le = !m_valid || out_ready;
        exp_rdy = (le && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "_out_data"}, 32'(out_data), 32'(m_data));
        chk({tag, "_out_ch"}, 32'(out_ch), 32'(m_ch));
        if (le) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = int'(in_data[g*8 +: 8]);
                m_ch    = g;
                if (!mode) m_ptr = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        tbl[1]  = '{1'b1, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        tbl[2]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        tbl[3]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        tbl[4]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        tbl[5]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        tbl[6]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        tbl[7]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        tbl[8]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        tbl[9]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        tbl[10] = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        tbl[11] = '{1'b0, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        tbl[12] = '{1'b0, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        tbl[13] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22};
        tbl[14] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22};
        tbl[15] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22};
        tbl[16] = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        tbl[17] = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA5};
        tbl[18] = '{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 8'hA5};

        rst = 1'b1;
        mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1; in_data = FIXED_DATA;
        b_mode = 1'b1; b_sel = 2'd0; b_valid = 3'b000; b_out_ready = 1'b1; b_data = 24'hC0B0A0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_ch", 32'(out_ch), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        // Directed vectors: fixed select, round-robin, sparse, backpressure, drain
        for (int r = 0; r < 19; r++) begin
            mode = tbl[r].mode; sel = tbl[r].sel; in_valid = tbl[r].valid; out_ready = tbl[r].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].exp_ov));
            chk($sformatf("vec%0d_out_ch", r), 32'(out_ch), 32'(tbl[r].exp_ch));
            chk($sformatf("vec%0d_out_data", r), 32'(out_data), 32'(tbl[r].exp_data));
        end

        // Reset mid-stream with a word held in the output register
        mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_out_ch", 32'(out_ch), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_data", 32'(out_data), 32'd0);
        chk("async_rst_out_ch", 32'(out_ch), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_valid = 1'b0; m_data = 0; m_ch = 0; m_ptr = N - 1;
        model_cycle("post_rst");
        chk("post_rst_first_ch", 32'(out_ch), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            mode      = ($urandom_range(0, 3) == 0);
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            model_cycle("rand");
        end

        // Three-channel instance: sel beyond the last channel never grants
        b_mode = 1'b1; b_sel = 2'd0; b_valid = 3'b111; b_out_ready = 1'b1;
        @(negedge clk);
        chk("ch3_sel0_in_ready", 32'(b_ready), 32'b001);
        @(posedge clk);
        #1;
        chk("ch3_sel0_out_valid", 32'(b_out_valid), 32'd1);
        chk("ch3_sel0_out_data", 32'(b_out_data), 32'hA0);
        b_sel = 2'd2;
        @(negedge clk);
        chk("ch3_sel2_in_ready", 32'(b_ready), 32'b100);
        @(posedge clk);
        #1;
        chk("ch3_sel2_out_ch", 32'(b_out_ch), 32'd2);
        b_sel = 2'd3;
        @(negedge clk);
        chk("ch3_sel3_in_ready", 32'(b_ready), 32'b000);
        @(posedge clk);
        #1;
        chk("ch3_sel3_out_valid", 32'(b_out_valid), 32'd0);
        chk("ch3_sel3_out_ch_hold", 32'(b_out_ch), 32'd2);
        @(posedge clk);
        #1;
        chk("ch3_sel3_stays_idle", 32'(b_out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
